// File: rtl/mpt_pkg.sv
// Shared types for the PLB lookup path: entry layout, access types, FSM states.
// Entry fields are sized for the widest supported paddr/sdid; narrower builds zero-extend.
package mpt_pkg;

    localparam int PAGE_OFFSET_WIDTH = 12;
    localparam int PPN_MAX_WIDTH     = 52;
    localparam int SDID_MAX_WIDTH    = 16;

    typedef enum logic [1:0] {
        ACC_READ  = 2'b00,
        ACC_WRITE = 2'b01,
        ACC_EXEC  = 2'b10,
        ACC_RSVD  = 2'b11
    } acc_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WALK_REQ  = 3'd2,
        WALK_WAIT = 3'd3,
        RESP      = 3'd4
    } plb_state_e;

    typedef struct packed {
        logic                      valid;
        logic [SDID_MAX_WIDTH-1:0] sdid;
        logic [PPN_MAX_WIDTH-1:0]  ppn;
        logic [2:0]                perm;
    } plb_entry_t;

    // perm is {x,w,r}; the reserved access type is never allowed.
    function automatic logic perm_allows(input logic [2:0] perm, input acc_e acc);
        case (acc)
            ACC_READ:  return perm[0];
            ACC_WRITE: return perm[1];
            ACC_EXEC:  return perm[2];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/plb_cam.sv
// Fully-associative PLB entry array: parallel match, install with victim choice, flush.
module plb_cam
    import mpt_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [SDID_MAX_WIDTH-1:0] lookup_sdid,
    input  logic [PPN_MAX_WIDTH-1:0]  lookup_ppn,
    output logic                      hit,
    output logic [2:0]                hit_perm,
    input  logic                      install,
    input  logic [2:0]                install_perm,
    output logic [NUM_ENTRIES-1:0]    valid_mask
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    plb_entry_t       entries [NUM_ENTRIES];
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;
    logic             have_free;

    always_comb begin
        hit      = 1'b0;
        hit_perm = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries[i].valid && entries[i].sdid == lookup_sdid &&
                entries[i].ppn == lookup_ppn && !flush) begin
                hit      = 1'b1;
                hit_perm = entries[i].perm;
            end
        end
    end

    // Scan downwards so the lowest-index free slot wins.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        victim = have_free ? free_idx : rr_ptr;
    end

    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_mask[i] = entries[i].valid;
        end
    end

    // Flush wins over a same-cycle install; install uses the lookup key.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            rr_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (install) begin
            entries[victim].valid <= 1'b1;
            entries[victim].sdid  <= lookup_sdid;
            entries[victim].ppn   <= lookup_ppn;
            entries[victim].perm  <= install_perm;
            if (!have_free) begin
                rr_ptr <= rr_ptr + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/plb_lookup_stage.sv
// PLB lookup stage: blocking permission check with walk/refill on miss.
// Optional build macro PLB_PERF_COUNTERS_EN adds saturating hit/miss counters.
module plb_lookup_stage
    import mpt_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int PADDR_WIDTH = 56,
    parameter int SDID_WIDTH  = 6,
    parameter int ID_WIDTH    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    input  logic [PADDR_WIDTH-1:0] req_paddr_i,
    input  logic [SDID_WIDTH-1:0]  req_sdid_i,
    input  logic [1:0]             req_acc_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_WIDTH-1:0]    rsp_id_o,
    output logic                   rsp_allow_o,
    output logic                   rsp_fault_o,
    output logic                   walk_valid_o,
    input  logic                   walk_ready_i,
    output logic [PADDR_WIDTH-1:0] walk_paddr_o,
    output logic [SDID_WIDTH-1:0]  walk_sdid_o,
    input  logic                   refill_valid_i,
    output logic                   refill_ready_o,
    input  logic [2:0]             refill_perm_i,
    input  logic                   refill_fault_i,
    input  logic                   flush_i,
`ifdef PLB_PERF_COUNTERS_EN
    output logic [31:0]            hit_count_o,
    output logic [31:0]            miss_count_o,
`endif
    output plb_state_e             state_o,
    output logic [NUM_ENTRIES-1:0] entry_valid_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // every valid here is a decode of the state register, never of the ready.

    plb_state_e             state;
    logic [ID_WIDTH-1:0]    cap_id;
    logic [PADDR_WIDTH-1:0] cap_paddr;
    logic [SDID_WIDTH-1:0]  cap_sdid;
    acc_e                   cap_acc;
    logic [ID_WIDTH-1:0]    rsp_id_q;
    logic                   rsp_allow_q;
    logic                   rsp_fault_q;

    logic                   hit;
    logic [2:0]             hit_perm;
    logic                   install;

    assign install = (state == WALK_WAIT) && refill_valid_i && !refill_fault_i;

    plb_cam #(.NUM_ENTRIES(NUM_ENTRIES)) u_cam (
        .clk          (clk_i),
        .rst          (rst_i),
        .flush        (flush_i),
        .lookup_sdid  (SDID_MAX_WIDTH'(cap_sdid)),
        .lookup_ppn   (PPN_MAX_WIDTH'(cap_paddr[PADDR_WIDTH-1:PAGE_OFFSET_WIDTH])),
        .hit          (hit),
        .hit_perm     (hit_perm),
        .install      (install),
        .install_perm (refill_perm_i),
        .valid_mask   (entry_valid_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cap_id      <= '0;
            cap_paddr   <= '0;
            cap_sdid    <= '0;
            cap_acc     <= ACC_READ;
            rsp_id_q    <= '0;
            rsp_allow_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        cap_id    <= req_id_i;
                        cap_paddr <= req_paddr_i;
                        cap_sdid  <= req_sdid_i;
                        cap_acc   <= acc_e'(req_acc_i);
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rsp_id_q    <= cap_id;
                        rsp_allow_q <= perm_allows(hit_perm, cap_acc);
                        rsp_fault_q <= 1'b0;
                        state       <= RESP;
                    end else begin
                        state <= WALK_REQ;
                    end
                end
                WALK_REQ: begin
                    if (walk_ready_i) begin
                        state <= WALK_WAIT;
                    end
                end
                WALK_WAIT: begin
                    if (refill_valid_i) begin
                        rsp_id_q    <= cap_id;
                        rsp_allow_q <= !refill_fault_i && perm_allows(refill_perm_i, cap_acc);
                        rsp_fault_q <= refill_fault_i;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PLB_PERF_COUNTERS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!hit && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt;
    assign miss_count_o = miss_cnt;
`endif

    assign req_ready_o    = (state == IDLE) && !rst_i;
    assign walk_valid_o   = (state == WALK_REQ);
    assign refill_ready_o = (state == WALK_WAIT);
    assign rsp_valid_o    = (state == RESP);
    assign walk_paddr_o   = cap_paddr;
    assign walk_sdid_o    = cap_sdid;
    assign rsp_id_o       = rsp_id_q;
    assign rsp_allow_o    = rsp_allow_q;
    assign rsp_fault_o    = rsp_fault_q;
    assign state_o        = state;

endmodule

// File: tb/tb_plb_lookup_stage.sv
// Directed bench for plb_lookup_stage: vector table plus reset corner sequences.
module tb_plb_lookup_stage;
    import mpt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_id = '0;
    logic [55:0] req_paddr = '0;
    logic [5:0]  req_sdid = '0;
    logic [1:0]  req_acc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_id;
    logic        rsp_allow;
    logic        rsp_fault;
    logic        walk_valid;
    logic        walk_ready = 1'b0;
    logic [55:0] walk_paddr;
    logic [5:0]  walk_sdid;
    logic        refill_valid = 1'b0;
    logic        refill_ready;
    logic [2:0]  refill_perm = '0;
    logic        refill_fault = 1'b0;
    logic        flush = 1'b0;
    plb_state_e  state;
    logic [7:0]  valid_mask;
`ifdef PLB_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_pass = 0;
    int n_total = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    plb_lookup_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_id_i       (req_id),
        .req_paddr_i    (req_paddr),
        .req_sdid_i     (req_sdid),
        .req_acc_i      (req_acc),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_allow_o    (rsp_allow),
        .rsp_fault_o    (rsp_fault),
        .walk_valid_o   (walk_valid),
        .walk_ready_i   (walk_ready),
        .walk_paddr_o   (walk_paddr),
        .walk_sdid_o    (walk_sdid),
        .refill_valid_i (refill_valid),
        .refill_ready_o (refill_ready),
        .refill_perm_i  (refill_perm),
        .refill_fault_i (refill_fault),
        .flush_i        (flush),
`ifdef PLB_PERF_COUNTERS_EN
        .hit_count_o    (hit_count),
        .miss_count_o   (miss_count),
`endif
        .state_o        (state),
        .entry_valid_o  (valid_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [55:0] paddr;
        logic [5:0]  sdid;
        logic [1:0]  acc;
        logic [2:0]  perm;
        logic        fault;
        logic        flush_refill;
        logic        flush_lookup;
        int          dly;
        int          bp;
        logic        exp_walk;
        logic        exp_allow;
        logic        exp_fault;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic [3:0] id, input logic [55:0] pa, input logic [5:0] sd,
                       input logic [1:0] acc, input logic [2:0] perm, input logic flt,
                       input logic flr, input logic flk, input int dly, input int bp,
                       input logic ew, input logic ea, input logic ef, input logic [7:0] em);
        vec_t v;
        v.id = id; v.paddr = pa; v.sdid = sd; v.acc = acc; v.perm = perm; v.fault = flt;
        v.flush_refill = flr; v.flush_lookup = flk; v.dly = dly; v.bp = bp;
        v.exp_walk = ew; v.exp_allow = ea; v.exp_fault = ef; v.exp_mask = em;
        vecs.push_back(v);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int t;
        int wwait;
        int rwait;
        int exp_lat;
        logic walk_seen;
        logic [55:0] wpa;
        logic [5:0] wsd;
        logic done;
        @(negedge clk);
        req_valid = 1'b1; req_id = v.id; req_paddr = v.paddr; req_sdid = v.sdid; req_acc = v.acc;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("v%0d_accept", idx), req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        t = 1; wwait = 0; rwait = 0; walk_seen = 1'b0; done = 1'b0; wpa = '0; wsd = '0;
        while (!done && t < 100) begin
            walk_ready = 1'b0; refill_valid = 1'b0; flush = 1'b0;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (t == 1 && v.flush_lookup) flush = 1'b1;
                if (walk_valid) begin
                    if (!walk_seen) begin
                        walk_seen = 1'b1; wpa = walk_paddr; wsd = walk_sdid;
                    end
                    if (wwait == v.dly) walk_ready = 1'b1;
                    else wwait++;
                end
                if (refill_ready) begin
                    if (rwait == v.dly) begin
                        refill_valid = 1'b1; refill_perm = v.perm; refill_fault = v.fault;
                        flush = v.flush_refill;
                    end else begin
                        rwait++;
                    end
                end
                @(negedge clk);
                t++;
            end
        end
        walk_ready = 1'b0; refill_valid = 1'b0; flush = 1'b0;
        chk($sformatf("v%0d_rsp_timeout", idx), done, 1'b1);
        if (!done) return;
        if (v.exp_walk) exp_misses++;
        else exp_hits++;
        exp_lat = v.exp_walk ? 4 + 2 * v.dly : 2;
        chk($sformatf("v%0d_latency", idx), 64'(t), 64'(exp_lat));
        chk($sformatf("v%0d_walked", idx), walk_seen, v.exp_walk);
        if (v.exp_walk) begin
            chk($sformatf("v%0d_walk_paddr", idx), wpa, v.paddr);
            chk($sformatf("v%0d_walk_sdid", idx), wsd, v.sdid);
        end
        chk($sformatf("v%0d_rsp_id", idx), rsp_id, v.id);
        chk($sformatf("v%0d_allow", idx), rsp_allow, v.exp_allow);
        chk($sformatf("v%0d_fault", idx), rsp_fault, v.exp_fault);
        rsp_ready = 1'b0;
        for (int k = 0; k < v.bp; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_hold%0d", idx, k),
                {rsp_valid, req_ready, rsp_id, rsp_allow, rsp_fault},
                {1'b1, 1'b0, v.id, v.exp_allow, v.exp_fault});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_retired", idx), {rsp_valid, req_ready}, 2'b01);
        chk($sformatf("v%0d_mask", idx), valid_mask, v.exp_mask);
    endtask

    initial begin
        int t;
        // id paddr sdid acc perm fault flush_refill flush_lookup dly bp | walk allow fault mask
        add(4'd3,  56'h1000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h01);
        add(4'd4,  56'h1FF8, 6'd1, 2'b01, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 8'h01);
        add(4'd5,  56'h1000, 6'd2, 2'b10, 3'b100, 0, 0, 0, 2, 0, 1, 1, 0, 8'h03);
        add(4'd6,  56'h1234, 6'd1, 2'b11, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 8'h03);
        add(4'd7,  56'h5000, 6'd1, 2'b00, 3'b111, 1, 0, 0, 0, 0, 1, 0, 1, 8'h03);
        add(4'd8,  56'h5000, 6'd1, 2'b00, 3'b011, 0, 0, 0, 2, 0, 1, 1, 0, 8'h07);
        add(4'd9,  56'h6000, 6'd1, 2'b01, 3'b010, 0, 1, 0, 0, 5, 1, 1, 0, 8'h00);
        add(4'd10, 56'h1000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h01);
        add(4'd11, 56'h2000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h03);
        add(4'd12, 56'h3000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h07);
        add(4'd13, 56'h4000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h0F);
        add(4'd14, 56'h5000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h1F);
        add(4'd15, 56'h6000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h3F);
        add(4'd0,  56'h7000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'h7F);
        add(4'd1,  56'h8000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'hFF);
        add(4'd2,  56'h9000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'hFF);
        add(4'd3,  56'h2000, 6'd1, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
        add(4'd4,  56'hA000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'hFF);
        add(4'd5,  56'h9000, 6'd1, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
        add(4'd6,  56'h3000, 6'd1, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
        add(4'd7,  56'h1000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'hFF);
        add(4'd8,  56'h4000, 6'd1, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF);
        add(4'd9,  56'h3000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'hFF);
        add(4'd10, 56'h2000, 6'd1, 2'b00, 3'b001, 0, 0, 0, 0, 0, 1, 1, 0, 8'hFF);
        add(4'd11, 56'h7008, 6'd1, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(4'd12, 56'h8000, 6'd1, 2'b00, 3'b001, 0, 0, 1, 0, 0, 1, 1, 0, 8'h01);

        // Clock/reset: check the reset state, then release.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_valids", {rsp_valid, walk_valid, refill_ready}, 3'b000);
        chk("rst_state", state, IDLE);
        chk("rst_mask", valid_mask, 8'h00);
        chk("rst_rsp_regs", {rsp_id, rsp_allow, rsp_fault}, 6'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], i);
        end

`ifdef PLB_PERF_COUNTERS_EN
        chk("hit_count", hit_count, 32'(exp_hits));
        chk("miss_count", miss_count, 32'(exp_misses));
`endif

        // Reset while waiting for the refill abandons the transaction.
        @(negedge clk);
        req_valid = 1'b1; req_id = 4'd13; req_paddr = 56'hB000; req_sdid = 6'd3; req_acc = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!refill_ready && t < 50) begin
            walk_ready = walk_valid;
            @(negedge clk);
            t++;
        end
        walk_ready = 1'b0;
        chk("midwalk_reach_wait", {refill_ready, state}, {1'b1, WALK_WAIT});
        rst = 1'b1;
        @(negedge clk);
        chk("midwalk_state", state, IDLE);
        chk("midwalk_refill_ready", refill_ready, 1'b0);
        chk("midwalk_mask", valid_mask, 8'h00);
        chk("midwalk_req_ready_in_rst", req_ready, 1'b0);
`ifdef PLB_PERF_COUNTERS_EN
        chk("midwalk_counters", {hit_count, miss_count}, 64'd0);
`endif
        rst = 1'b0;
        refill_valid = 1'b1; refill_perm = 3'b111; refill_fault = 1'b0;
        @(negedge clk);
        chk("late_refill_ignored", {refill_ready, state, req_ready, valid_mask}, {1'b0, IDLE, 1'b1, 8'h00});
        refill_valid = 1'b0;
        @(negedge clk);
        chk("late_refill_no_install", valid_mask, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
